// File: rtl/io_input_queue_pkg.sv
// Shared constants for the switch-bank input queue and the DMA that drains it.
package io_input_queue_pkg;

  localparam int IO_DATA_W          = 22;
  localparam int IO_DEPTH           = 32;
  localparam int IO_DEBOUNCE_CYCLES = 16;
  localparam int IO_COUNT_W         = $clog2(IO_DEPTH) + 1;

endpackage : io_input_queue_pkg

// File: rtl/io_input_queue_btn_debounce.sv
// Synchronizes the raw active-low apply button, debounces it and emits a
// one-cycle press strobe on the debounced 1->0 transition only.
module btn_debounce
  import io_input_queue_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = IO_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1;
  logic             sync2;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchronizer; idles at 1 (button released).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Accept a new level after DEBOUNCE_CYCLES consecutive differing samples;
  // any sample matching the current level restarts the count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      level_q <= 1'b1;
    end else if (sync2 != level_q) begin
      if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_q <= sync2;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  // Delayed copy of the debounced level for edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) level_d <= 1'b1;
    else       level_d <= level_q;
  end

  assign press = level_d & ~level_q;

endmodule : btn_debounce

// File: rtl/io_input_queue.sv
// Captures the switch bank into a FIFO each time the apply button is
// pressed. The consumer reads the head show-ahead on rd_data.
//
// Consumer handshake: rd_data/empty describe the head this cycle; asserting
// pop while empty == 0 removes the head at the next rising edge. pop while
// empty is ignored. There is no backpressure on the producer side: a press
// that finds the queue full (with no pop that cycle) is dropped and latches
// the sticky overflow flag until reset.
module io_input_queue
  import io_input_queue_pkg::*;
#(
  parameter int DATA_W          = IO_DATA_W,
  parameter int DEPTH           = IO_DEPTH,
  parameter int DEBOUNCE_CYCLES = IO_DEBOUNCE_CYCLES
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      apply_btn,
  input  logic [DATA_W-1:0]         io_in,
  input  logic                      pop,
  output logic [DATA_W-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty,
  output logic                      full,
  output logic                      overflow
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [DATA_W-1:0] io_sync1;
  logic [DATA_W-1:0] io_sync2;
  logic              push;
  logic              do_push;
  logic              do_pop;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clock   (clock),
    .reset   (reset),
    .btn_raw (apply_btn),
    .press   (push)
  );

  // Two-flop synchronizer for the switch bank.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      io_sync1 <= '0;
      io_sync2 <= '0;
    end else begin
      io_sync1 <= io_in;
      io_sync2 <= io_sync1;
    end
  end

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= io_sync2;
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  // Show-ahead head entry, forced to zero when nothing is held.
  always_comb begin
    rd_data = '0;
    if (!empty) rd_data = mem[rd_ptr];
  end

endmodule : io_input_queue

// File: tb/tb_io_input_queue.sv
// Directed bench for io_input_queue: press, bounce, fill/overflow, drain,
// simultaneous push/pop, pop on empty and asynchronous reset.
module tb_io_input_queue;

  localparam int DATA_W = 22;
  localparam int DEPTH  = 32;

  logic              clock;
  logic              reset;
  logic              apply_btn;
  logic [DATA_W-1:0] io_in;
  logic              pop;
  logic [DATA_W-1:0] rd_data;
  logic [5:0]        count;
  logic              empty;
  logic              full;
  logic              overflow;

  int checks = 0;
  int errors = 0;

  io_input_queue #(
    .DATA_W          (DATA_W),
    .DEPTH           (DEPTH),
    .DEBOUNCE_CYCLES (16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .apply_btn (apply_btn),
    .io_in     (io_in),
    .pop       (pop),
    .rd_data   (rd_data),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow)
  );

  // Clock generation.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance n cycles, ending 1 time unit after the rising edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic press(input logic [DATA_W-1:0] v, input int low, input int high);
    io_in     = v;
    apply_btn = 1'b0;
    cyc(low);
    apply_btn = 1'b1;
    cyc(high);
  endtask

  task automatic pop_one();
    pop = 1'b1;
    cyc(1);
    pop = 1'b0;
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Wait (bounded) for the internal push strobe, leaving the bench mid-cycle
  // while the strobe is high so pop can be applied in the same cycle.
  task automatic wait_push(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (dut.push) begin
        seen = 1'b1;
        break;
      end
      cyc(1);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL push_strobe_timeout: got 0 expected 1");
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    apply_btn = 1'b1;
    io_in     = '0;
    pop       = 1'b0;
    cyc(3);
    check_val("reset_count", 32'(count), 32'd0);
    check_val("reset_empty", 32'(empty), 32'd1);
    check_val("reset_full", 32'(full), 32'd0);
    check_val("reset_overflow", 32'(overflow), 32'd0);
    check_val("reset_rd_data", 32'(rd_data), 32'd0);
    reset = 1'b0;
    cyc(3);
  endtask

  task automatic test_single_press();
    press(22'h15A5A, 40, 40);
    check_val("single_count", 32'(count), 32'd1);
    check_val("single_rd_data", 32'(rd_data), 32'h15A5A);
    check_val("single_empty", 32'(empty), 32'd0);
    pop_one();
    check_val("single_pop_empty", 32'(empty), 32'd1);
  endtask

  task automatic test_bounce();
    io_in     = 22'h0BEEF;
    apply_btn = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc(5);
      apply_btn = ~apply_btn;
    end
    apply_btn = 1'b0;
    cyc(40);
    apply_btn = 1'b1;
    cyc(40);
    check_val("bounce_count", 32'(count), 32'd1);
    check_val("bounce_rd_data", 32'(rd_data), 32'h0BEEF);
    pop_one();
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 32; i++) press(DATA_W'(i), 30, 30);
    check_val("fill32_count", 32'(count), 32'd32);
    check_val("fill32_overflow", 32'(overflow), 32'd0);
    press(DATA_W'(33), 30, 30);
    check_val("fill33_full", 32'(full), 32'd1);
    check_val("fill33_count", 32'(count), 32'd32);
    check_val("fill33_overflow", 32'(overflow), 32'd1);
    for (int i = 1; i <= 32; i++) begin
      check_val($sformatf("drain_%0d", i), 32'(rd_data), 32'(i));
      pop_one();
    end
    check_val("drain_empty", 32'(empty), 32'd1);
    check_val("drain_rd_data", 32'(rd_data), 32'd0);
    check_val("drain_overflow_sticky", 32'(overflow), 32'd1);
  endtask

  task automatic test_pop_empty();
    pop = 1'b1;
    cyc(10);
    pop = 1'b0;
    check_val("pop_empty_count", 32'(count), 32'd0);
    press(22'h2ABCD, 30, 30);
    check_val("pop_empty_next_count", 32'(count), 32'd1);
    check_val("pop_empty_next_data", 32'(rd_data), 32'h2ABCD);
    pop_one();
  endtask

  task automatic test_push_pop_empty();
    bit seen;
    io_in     = 22'h00777;
    pop       = 1'b1;
    apply_btn = 1'b0;
    wait_push(seen);
    cyc(1);
    pop = 1'b0;
    check_val("pp_empty_count", 32'(count), 32'd1);
    check_val("pp_empty_data", 32'(rd_data), 32'h00777);
    apply_btn = 1'b1;
    cyc(30);
    pop_one();
  endtask

  task automatic test_push_pop_full();
    bit seen;
    for (int i = 1; i <= 32; i++) press(DATA_W'(i + 100), 30, 30);
    check_val("ppf_pre_count", 32'(count), 32'd32);
    io_in     = 22'h3C0DE;
    apply_btn = 1'b0;
    wait_push(seen);
    pop = 1'b1;
    cyc(1);
    pop = 1'b0;
    check_val("ppf_count", 32'(count), 32'd32);
    check_val("ppf_overflow", 32'(overflow), 32'd1);
    check_val("ppf_head", 32'(rd_data), 32'd102);
    apply_btn = 1'b1;
    cyc(30);
    for (int i = 2; i <= 32; i++) pop_one();
    check_val("ppf_tail", 32'(rd_data), 32'h3C0DE);
    pop_one();
    check_val("ppf_final_empty", 32'(empty), 32'd1);
  endtask

  task automatic test_async_reset();
    for (int i = 1; i <= 5; i++) press(DATA_W'(i * 7), 30, 30);
    check_val("ar_pre_count", 32'(count), 32'd5);
    io_in     = 22'h11111;
    apply_btn = 1'b0;
    cyc(8);
    #3;
    reset = 1'b1;
    #1;
    check_val("ar_count", 32'(count), 32'd0);
    check_val("ar_empty", 32'(empty), 32'd1);
    check_val("ar_full", 32'(full), 32'd0);
    check_val("ar_overflow", 32'(overflow), 32'd0);
    check_val("ar_rd_data", 32'(rd_data), 32'd0);
    apply_btn = 1'b1;
    #2;
    reset = 1'b0;
    cyc(40);
    check_val("ar_no_push", 32'(count), 32'd0);
    press(22'h01234, 30, 30);
    check_val("ar_fresh_count", 32'(count), 32'd1);
    check_val("ar_fresh_data", 32'(rd_data), 32'h01234);
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_fill_overflow();
    test_pop_empty();
    test_push_pop_empty();
    test_push_pop_full();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_io_input_queue

// File: doc/io_input_queue.md
IO_INPUT_QUEUE -- requirements
Module: io_input_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 22, width of one input sample (switch bank).
REQ-002 SHALL have parameter DEPTH, default 32, number of queue entries (power of two).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 16, stable cycles required before the button level is accepted.
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port apply_btn  input  1  raw push button, active-low (pressed = 0), asynchronous to clock.
REQ-007 SHALL have port io_in  input  DATA_W  raw switch values, asynchronous to clock.
REQ-008 SHALL have port pop  input  1  consumer (DMA) removes head entry this cycle.
REQ-009 SHALL have port rd_data  output  DATA_W  head entry; all-zero when empty.
REQ-010 SHALL have port count  output  $clog2(DEPTH)+1  entries held, 0..DEPTH.
REQ-011 SHALL have port empty  output  1  count == 0.
REQ-012 SHALL have port full  output  1  count == DEPTH.
REQ-013 SHALL have port overflow  output  1  sticky: a press was dropped because the queue was full.

Function
REQ-014 SHALL pass apply_btn and io_in each through a 2-flop synchronizer before any use.
REQ-015 SHALL accept a new debounced button level only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the counter from 0.
REQ-016 SHALL generate a one-cycle push strobe on the debounced 1->0 transition (press) only; release generates nothing.
REQ-017 SHALL write the synchronized io_in value present in the strobe cycle into the tail entry, and count/rd_data SHALL reflect it on the next cycle.
REQ-018 SHALL have rd_data show the head entry combinationally from registered storage (show-ahead); pop advances the head on the next edge.
REQ-019 SHALL ignore pop when empty (no pointer or count change).
REQ-020 SHALL, on push while full and without pop in the same cycle, drop the sample, keep the pointers, and set overflow.
REQ-021 SHALL, on simultaneous push and pop when non-empty (including full), perform both and leave count unchanged.
REQ-022 SHALL, on simultaneous push and pop when empty, perform the push only (count becomes 1).
REQ-023 SHALL wrap read and write pointers modulo DEPTH; count SHALL never exceed DEPTH nor go below 0.
REQ-024 SHALL clear overflow only on reset.

Reset
REQ-025 SHALL on reset assertion, immediately and regardless of clock: pointers = 0, count = 0, empty = 1, full = 0, overflow = 0, rd_data = 0, debounce counter = 0, debounced level = 1 (released), synchronizer flops = 1 for the button and 0 for io_in.
REQ-026 SHALL, if reset asserts mid-debounce or mid-push, discard that event; no push after reset release until a full fresh press is debounced.
REQ-027 SHALL not require storage-array contents to be cleared; only the pointers define validity.

Structure
REQ-028 SHALL put DATA_W, DEPTH and DEBOUNCE_CYCLES defaults and the count-width constant in the shared io package used by the DMA.
REQ-029 SHALL implement synchronizer, debounce and press-edge detection as one sub-module, btn_debounce, instantiated once.

Verification
REQ-030 SHALL cover single press: io_in = 0x15A5A, clean press held 40 cycles -> exactly one push; count = 1, rd_data = 0x15A5A, empty = 0.
REQ-031 SHALL cover bounce: button toggled every 5 cycles for 60 cycles, then held low 40 cycles -> exactly one push.
REQ-032 SHALL cover fill and overflow: 33 presses with io_in = 1..33 -> full = 1, count = 32, overflow = 1; popping all 32 returns 1..32 in order, then empty = 1 and rd_data = 0.
REQ-033 SHALL cover simultaneous push and pop: count = 32, pop and push strobe in the same cycle -> count stays 32, overflow unchanged, new value at the tail.
REQ-034 SHALL cover pop on empty: pop held 10 cycles with count = 0 -> count remains 0 and pointers are unchanged (the next push reads back correctly).
REQ-035 SHALL cover async reset: reset pulsed between clock edges with count = 5 and the button mid-debounce -> outputs at reset values immediately, and no push is generated after release.
